updown_counter_mod: RTL and testbench



---
 rtl/updown_counter_mod.sv | 109 ++++++++++
 tb/tb_updown_counter_mod.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
// Parametrised modulo-MOD up/down counter with synchronous parallel load,
// count enable, run-time direction and wrap/saturate boundary mode.
// tc is combinational and flags that this cycle's update crosses a range
// boundary. wrapped is a registered one-cycle pulse after a wrapping update.
//
// Optional feature macro: UDC_STEP_EN
//   defined   -> adds input port 'step' (per-cycle magnitude, clamped to MOD-1)
//   undefined -> step magnitude is the constant 1
//
// All internal arithmetic is N+1 bits wide so MOD = 2**N and count+step
// never truncate before the boundary decision is made.
// -----------------------------------------------------------------------------
module updown_counter_mod #(
   parameter int N       = 8,
   parameter int MOD     = 256,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         up,
   input  logic         sat,
   input  logic         load,
   input  logic [N-1:0] load_val,
`ifdef UDC_STEP_EN
   input  logic [N-1:0] step,
`endif
   output logic [N-1:0] count,
   output logic         tc,
   output logic         wrapped
);

   localparam logic [N:0]   L_MOD = (N+1)'(MOD);
   localparam logic [N:0]   L_MAX = (N+1)'(MOD - 1);
   localparam logic [N-1:0] L_RST = N'(RST_VAL);

   logic [N-1:0] r_count;
   logic         r_wrapped;

   logic [N:0]   w_s;
   logic [N:0]   w_cnt_ext;
   logic [N:0]   w_sum;
   logic [N:0]   w_diff;
   logic [N:0]   w_up_wrap;
   logic [N:0]   w_dn_wrap;
   logic [N:0]   w_next_ext;
   logic [N-1:0] w_load_clamped;
   logic         w_ovf;
   logic         w_unf;
   logic         w_tc;

   // Effective step magnitude for this cycle.
   always_comb begin
`ifdef UDC_STEP_EN
      w_s = ({1'b0, step} >= L_MOD) ? L_MAX : {1'b0, step};
`else
      w_s = (N+1)'(1);
`endif
   end

   assign w_cnt_ext = {1'b0, r_count};
   assign w_sum     = w_cnt_ext + w_s;
   assign w_diff    = w_cnt_ext - w_s;
   assign w_up_wrap = w_sum - L_MOD;
   assign w_dn_wrap = w_cnt_ext + L_MOD - w_s;

   // Boundary detection on the current count and inputs.
   assign w_ovf = up & (w_sum > L_MAX);
   assign w_unf = !up & (w_s > w_cnt_ext);
   assign w_tc  = reset_n & en & !load & (w_ovf | w_unf);

   // Load value is clamped into the legal range rather than wrapped.
   assign w_load_clamped = ({1'b0, load_val} >= L_MOD) ? N'(L_MAX) : load_val;

   // Next count for an enabled (non-load) cycle, applying wrap or saturate.
   always_comb begin
      w_next_ext = w_sum;
      if (up) begin
         if (w_ovf) w_next_ext = sat ? L_MAX : w_up_wrap;
         else       w_next_ext = w_sum;
      end else begin
         if (w_unf) w_next_ext = sat ? '0 : w_dn_wrap;
         else       w_next_ext = w_diff;
      end
   end

   // Count and wrap-pulse registers: reset > load > enable > hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count   <= L_RST;
         r_wrapped <= 1'b0;
      end else if (load) begin
         r_count   <= w_load_clamped;
         r_wrapped <= 1'b0;
      end else if (en) begin
         r_count   <= N'(w_next_ext);
         r_wrapped <= w_tc & !sat;
      end else begin
         r_wrapped <= 1'b0;
      end
   end

   assign count   = r_count;
   assign tc      = w_tc;
   assign wrapped = r_wrapped;

endmodule

// File: tb/tb_updown_counter_mod.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_mod
// Directed scenarios plus randomized traffic for updown_counter_mod
// (N=8, MOD=10, RST_VAL=3). The reference model tracks the count as a plain
// integer and applies modulo arithmetic on it. Step scenarios are compiled
// in when UDC_STEP_EN is defined.
// -----------------------------------------------------------------------------
module tb_updown_counter_mod;

   localparam int N       = 8;
   localparam int MOD     = 10;
   localparam int RST_VAL = 3;

   // ---------------- clock / reset / DUT signals ----------------
   logic         clk = 1'b0;
   logic         reset_n;
   logic         en;
   logic         up;
   logic         sat;
   logic         load;
   logic [N-1:0] load_val;
`ifdef UDC_STEP_EN
   logic [N-1:0] step;
`endif
   logic [N-1:0] count;
   logic         tc;
   logic         wrapped;

   always #5 clk = ~clk;

   updown_counter_mod #(.N(N), .MOD(MOD), .RST_VAL(RST_VAL)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en),
      .up       (up),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
`ifdef UDC_STEP_EN
      .step     (step),
`endif
      .count    (count),
      .tc       (tc),
      .wrapped  (wrapped)
   );

   // ---------------- reference model ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int m_count  = 0;
   bit m_wrapped = 1'b0;

   function automatic int eff_step();
`ifdef UDC_STEP_EN
      return (int'(step) >= MOD) ? MOD - 1 : int'(step);
`else
      return 1;
`endif
   endfunction

   // Would this cycle's enabled update leave the range 0..MOD-1?
   function automatic bit exp_tc();
      int s;
      if (!reset_n || load || !en) return 1'b0;
      s = eff_step();
      if (up) return (m_count + s) >= MOD;
      else    return (m_count - s) < 0;
   endfunction

   // Advance one clock: posedge updates the model, return on the next negedge.
   task automatic tick();
      bit t;
      int s;
      int raw;
      t = exp_tc();
      s = eff_step();
      @(posedge clk);
      if (!reset_n) begin
         m_count   = RST_VAL;
         m_wrapped = 1'b0;
      end else if (load) begin
         m_count   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
         m_wrapped = 1'b0;
      end else if (en) begin
         raw = up ? m_count + s : m_count - s;
         if (t && sat) m_count = up ? MOD - 1 : 0;
         else          m_count = ((raw % MOD) + MOD) % MOD;
         m_wrapped = t && !sat;
      end else begin
         m_wrapped = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic set_in(input bit rn, input bit ld, input int lv,
                         input bit e, input bit u, input bit sm);
      reset_n  = rn;
      load     = ld;
      load_val = N'(lv);
      en       = e;
      up       = u;
      sat      = sm;
   endtask

   // ---------------- test scenarios ----------------
   task automatic test_reset();
      set_in(1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc); end
      tick();
      tick();
      n_checks++;
      if (count !== N'(3)) begin n_fail++; $display("FAIL reset_count: got %0d want 3", count); end
      n_checks++;
      if (wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
      n_checks++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc_held: got %b want 0", tc); end
   endtask

   task automatic test_wrap_up();
      set_in(1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_up_tc: got %b want 1", tc); end
      tick();
      n_checks++;
      if (count !== N'(0)) begin n_fail++; $display("FAIL wrap_up_count: got %0d want 0", count); end
      n_checks++;
      if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_up_pulse: got %b want 1", wrapped); end
      en = 1'b0;
      tick();
      n_checks++;
      if (wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_up_pulse_end: got %b want 0", wrapped); end
   endtask

   task automatic test_wrap_down_sat();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_tc: got %b want 1", tc); end
      tick();
      n_checks++;
      if (count !== N'(9)) begin n_fail++; $display("FAIL wrap_dn_count: got %0d want 9", count); end
      set_in(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (tc !== 1'b1) begin n_fail++; $display("FAIL sat_dn_tc[%0d]: got %b want 1", i, tc); end
         tick();
         n_checks++;
         if (count !== N'(0) || wrapped !== 1'b0) begin
            n_fail++; $display("FAIL sat_dn_hold[%0d]: got count %0d wrapped %b want 0/0", i, count, wrapped);
         end
      end
      // Saturated hold at the top of the range.
      set_in(1'b1, 1'b1, 9, 1'b0, 1'b1, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (tc !== 1'b1) begin n_fail++; $display("FAIL sat_up_tc[%0d]: got %b want 1", i, tc); end
         tick();
         n_checks++;
         if (count !== N'(9) || wrapped !== 1'b0) begin
            n_fail++; $display("FAIL sat_up_hold[%0d]: got count %0d wrapped %b want 9/0", i, count, wrapped);
         end
      end
   endtask

   task automatic test_load_clamp();
      set_in(1'b1, 1'b1, 15, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL load_tc: got %b want 0", tc); end
      tick();
      n_checks++;
      if (count !== N'(9)) begin n_fail++; $display("FAIL load_clamp: got %0d want 9", count); end
      load_val = N'(4);
      tick();
      n_checks++;
      if (count !== N'(4) || wrapped !== 1'b0) begin
         n_fail++; $display("FAIL load_4: got count %0d wrapped %b want 4/0", count, wrapped);
      end
   endtask

   task automatic test_hold_dir();
      int exp_seq [4] = '{6, 7, 6, 7};
      bit dir_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      set_in(1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0);
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         up = 1'(i % 2);
         #1;
         n_checks++;
         if (tc !== 1'b0) begin n_fail++; $display("FAIL hold_tc[%0d]: got %b want 0", i, tc); end
         tick();
         n_checks++;
         if (count !== N'(5)) begin n_fail++; $display("FAIL hold_count[%0d]: got %0d want 5", i, count); end
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up = dir_seq[i];
         tick();
         n_checks++;
         if (count !== N'(exp_seq[i])) begin
            n_fail++; $display("FAIL dir_change[%0d]: got %0d want %0d", i, count, exp_seq[i]);
         end
      end
   endtask

`ifdef UDC_STEP_EN
   task automatic test_step();
      set_in(1'b1, 1'b1, 8, 1'b0, 1'b1, 1'b0);
      step = N'(3);
      tick();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (count !== N'(1) || wrapped !== 1'b1) begin
         n_fail++; $display("FAIL step_wrap: got count %0d wrapped %b want 1/1", count, wrapped);
      end
      step = N'(0);
      #1;
      n_checks++;
      if (tc !== 1'b0) begin n_fail++; $display("FAIL step0_tc: got %b want 0", tc); end
      tick();
      n_checks++;
      if (count !== N'(1) || wrapped !== 1'b0) begin
         n_fail++; $display("FAIL step0_hold: got count %0d wrapped %b want 1/0", count, wrapped);
      end
      set_in(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
      step = N'(12);
      tick();
      n_checks++;
      if (count !== N'(0) || wrapped !== 1'b0) begin
         n_fail++; $display("FAIL step_clamp_sat: got count %0d wrapped %b want 0/0", count, wrapped);
      end
   endtask
`endif

   task automatic test_random();
      bit t;
      for (int i = 0; i < 400; i++) begin
         set_in(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom));
`ifdef UDC_STEP_EN
         step = N'($urandom_range(0, 13));
`endif
         #1;
         t = exp_tc();
         n_checks++;
         if (tc !== t) begin n_fail++; $display("FAIL rand_tc[%0d]: got %b want %b", i, tc, t); end
         tick();
         n_checks++;
         if (count !== N'(m_count) || wrapped !== m_wrapped) begin
            n_fail++;
            $display("FAIL rand_state[%0d]: got count %0d wrapped %b want %0d/%b",
                     i, count, wrapped, m_count, m_wrapped);
         end
      end
   endtask

   // ---------------- sequencing and report ----------------
   initial begin
      set_in(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
`ifdef UDC_STEP_EN
      step = N'(1);
`endif
      @(negedge clk);
      test_reset();
      test_wrap_up();
      test_wrap_down_sat();
      test_load_clamp();
      test_hold_dir();
`ifdef UDC_STEP_EN
      test_step();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
